// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that fills instruction memory and releases the core on a good checksum
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_run_o,
  output logic              load_error_o,
  output logic [15:0]       words_loaded_o
);
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  localparam logic [15:0] DEPTH_L = 16'(DEPTH);
  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d, cnt_q, cnt_d, len_full;
  logic [7:0]        csum_q, csum_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       word_q, word_d;
  logic              we_q, we_d, acc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  assign rx_ready_o     = state_q != S_DONE && state_q != S_ERR;
  assign acc            = rx_valid_i && rx_ready_o;
  assign len_full       = {rx_data_i, len_q[7:0]};
  assign imem_we_o      = we_q;
  assign imem_addr_o    = addr_q;
  assign imem_wdata_o   = wdata_q;
  assign core_run_o     = state_q == S_DONE;
  assign load_error_o   = state_q == S_ERR;
  assign words_loaded_o = cnt_q;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (acc) begin
      csum_d = state_q == S_CSUM ? csum_q : csum_q ^ rx_data_i;
      case (state_q)
        S_LEN0: begin
          len_d[7:0] = rx_data_i;
          state_d    = S_LEN1;
        end
        S_LEN1: begin
          len_d[15:8] = rx_data_i;
          state_d     = len_full > DEPTH_L ? S_ERR : len_full == 16'd0 ? S_CSUM : S_DATA;
        end
        S_DATA: begin
          // bytes arrive LSB first, so shift down from the top of the assembly register
          idx_d  = idx_q + 2'd1;
          word_d = {rx_data_i, word_q[23:8]};
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = {rx_data_i, word_q};
            cnt_d   = cnt_q + 16'd1;
            state_d = cnt_d == len_q ? S_CSUM : S_DATA;
          end
        end
        S_CSUM: state_d = rx_data_i == csum_q ? S_DONE : S_ERR;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_LEN0;
      len_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frames against a frame-level reference model
module tb_imem_loader;
  typedef logic [7:0] bq_t[$];
  logic        clk = 0, rst_n = 0, rx_valid = 0;
  logic [7:0]  rx_data = 0;
  logic        rx_ready, imem_we, core_run, load_error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] words_loaded;
  int          errors = 0, checks = 0;
  logic [39:0] got_q[$], exp_q[$];
  logic        exp_run, exp_err;
  logic [15:0] exp_cnt;
  imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .rx_ready_o(rx_ready), .imem_we_o(imem_we), .imem_addr_o(imem_addr),
    .imem_wdata_o(imem_wdata), .core_run_o(core_run), .load_error_o(load_error),
    .words_loaded_o(words_loaded)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n && imem_we) got_q.push_back({imem_addr, imem_wdata});
  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model(input bq_t f);
    logic [15:0] len;
    logic [7:0]  x;
    exp_q.delete();
    len = {f[1], f[0]};
    exp_cnt = 0; exp_run = 0; exp_err = 0;
    if (len > 256) begin
      exp_err = 1;
      return;
    end
    for (int k = 0; k < int'(len); k++)
      exp_q.push_back({8'(k), f[2+4*k+3], f[2+4*k+2], f[2+4*k+1], f[2+4*k]});
    x = 0;
    for (int i = 0; i < f.size() - 1; i++) x ^= f[i];
    exp_cnt = len;
    exp_run = f[f.size()-1] == x;
    exp_err = !exp_run;
  endtask
  task automatic do_reset();
    rst_n = 0;
    rx_valid = 0;
    repeat (2) @(negedge clk);
    got_q.delete();
    chk("rst_ready", 40'(rx_ready), 40'd1);
    chk("rst_we", 40'(imem_we), 40'd0);
    chk("rst_addr_data", {imem_addr, imem_wdata}, 40'd0);
    chk("rst_run_err", {core_run, load_error}, 40'd0);
    chk("rst_words", 40'(words_loaded), 40'd0);
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    if (gap > 0) begin
      rx_valid = 0;
      rx_data = 8'($urandom);
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1;
    rx_data = b;
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("accept_timeout", 40'd0, 40'd1);
    else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic send_frame(input bq_t f, input int maxgap, input int upto);
    for (int i = 0; i < upto; i++) send_byte(f[i], $urandom_range(maxgap, 0));
    rx_valid = 0;
  endtask
  task automatic check_result(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_nwr"}, 40'(got_q.size()), 40'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_wr"}, got_q[i], exp_q[i]);
    chk({tag, "_words"}, 40'(words_loaded), 40'(exp_cnt));
    chk({tag, "_run_err"}, {core_run, load_error}, {38'd0, exp_run, exp_err});
    chk({tag, "_ready_we"}, {rx_ready, imem_we}, 40'd0);
  endtask
  task automatic run_frame(input string tag, input bq_t f, input int maxgap);
    do_reset();
    model(f);
    send_frame(f, maxgap, f.size());
    check_result(tag);
  endtask
  function automatic bq_t rand_frame(input int n, input bit bad);
    bq_t f;
    logic [7:0] x = 0;
    f.push_back(8'(n));
    f.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) f.push_back(8'($urandom));
    foreach (f[i]) x ^= f[i];
    f.push_back(bad ? x ^ 8'(1 << $urandom_range(7, 0)) : x);
    return f;
  endfunction
  initial begin
    bq_t nom, f;
    nom = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC3};
    run_frame("nominal", nom, 0);
    if (got_q.size() == 2) begin
      chk("nom_w0", got_q[0], {8'd0, 32'h00500093});
      chk("nom_w1", got_q[1], {8'd1, 32'h00100113});
    end else chk("nom_count", 40'(got_q.size()), 40'd2);
    run_frame("zero_len", '{8'h00, 8'h00, 8'h00}, 0);
    f = nom;
    f[10] = 8'hC2;
    run_frame("bad_csum", f, 0);
    run_frame("irregular", nom, 5);
    do_reset();
    model('{8'h01, 8'h01});
    send_frame('{8'h01, 8'h01}, 0, 2);
    rx_valid = 1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 0;
    check_result("overflow");
    do_reset();
    send_frame(nom, 0, 6);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_ready", 40'(rx_ready), 40'd1);
    chk("mid_rst_out", {imem_we, imem_addr, core_run, load_error, words_loaded}, 40'd0);
    @(negedge clk);
    got_q.delete();
    rst_n = 1;
    @(negedge clk);
    model(nom);
    send_frame(nom, 2, nom.size());
    check_result("after_rst");
    for (int r = 0; r < 20; r++) begin
      f = rand_frame($urandom_range(9, 0), $urandom_range(3, 0) == 0);
      run_frame("rand", f, $urandom_range(3, 0));
    end
    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(65535, 257);
      do_reset();
      f = '{8'(n), 8'(n >> 8)};
      model(f);
      send_frame(f, 2, 2);
      check_result("rand_ovf");
    end
    run_frame("max_len", rand_frame(256, 0), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
